// File: rtl/cpu_pkg.sv
// Shared constants for the control sequencer: IR field positions, opcodes, ALU codes, state encoding.
// CU_MULDIV_EN adds the T6 state and the mul/div decode; without it mul/div decode as nop.
package cpu_pkg;

  localparam int IR_OP_HI = 31;
  localparam int IR_OP_LO = 27;
  localparam int IR_RA_HI = 26;
  localparam int IR_RA_LO = 23;
  localparam int IR_RB_HI = 22;
  localparam int IR_RB_LO = 19;
  localparam int IR_RC_HI = 18;
  localparam int IR_RC_LO = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SHR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_ROR = 4'h6;
  localparam logic [3:0] ALU_ROL = 4'h7;
  localparam logic [3:0] ALU_MUL = 4'h8;
  localparam logic [3:0] ALU_DIV = 4'h9;
  localparam logic [3:0] ALU_NEG = 4'hA;
  localparam logic [3:0] ALU_NOT = 4'hB;

`ifdef CU_MULDIV_EN
  localparam int ST_W = 4;
`else
  localparam int ST_W = 3;
`endif

  localparam logic [ST_W-1:0] ST_RESET = ST_W'(0);
  localparam logic [ST_W-1:0] ST_T0    = ST_W'(1);
  localparam logic [ST_W-1:0] ST_T1    = ST_W'(2);
  localparam logic [ST_W-1:0] ST_T2    = ST_W'(3);
  localparam logic [ST_W-1:0] ST_T3    = ST_W'(4);
  localparam logic [ST_W-1:0] ST_T4    = ST_W'(5);
  localparam logic [ST_W-1:0] ST_T5    = ST_W'(6);
  localparam logic [ST_W-1:0] ST_HALT  = ST_W'(7);
`ifdef CU_MULDIV_EN
  localparam logic [ST_W-1:0] ST_T6    = ST_W'(8);
`endif

  typedef struct packed {
    logic       exec;
    logic       halt;
    logic       unary;
    logic       muldiv;
    logic [3:0] alu;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [4:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_ADD:  begin d.exec = 1'b1; d.alu = ALU_ADD; end
      OP_SUB:  begin d.exec = 1'b1; d.alu = ALU_SUB; end
      OP_SHR:  begin d.exec = 1'b1; d.alu = ALU_SHR; end
      OP_SHL:  begin d.exec = 1'b1; d.alu = ALU_SHL; end
      OP_ROR:  begin d.exec = 1'b1; d.alu = ALU_ROR; end
      OP_ROL:  begin d.exec = 1'b1; d.alu = ALU_ROL; end
      OP_AND:  begin d.exec = 1'b1; d.alu = ALU_AND; end
      OP_OR:   begin d.exec = 1'b1; d.alu = ALU_OR;  end
      OP_MUL: begin
        d.alu = ALU_MUL;
`ifdef CU_MULDIV_EN
        d.exec = 1'b1; d.muldiv = 1'b1;
`endif
      end
      OP_DIV: begin
        d.alu = ALU_DIV;
`ifdef CU_MULDIV_EN
        d.exec = 1'b1; d.muldiv = 1'b1;
`endif
      end
      OP_NEG:  begin d.exec = 1'b1; d.unary = 1'b1; d.alu = ALU_NEG; end
      OP_NOT:  begin d.exec = 1'b1; d.unary = 1'b1; d.alu = ALU_NOT; end
      OP_HALT: d.halt = 1'b1;
      OP_NOP:  d = '0;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_select.sv
// 4-to-NREGS one-hot register selector; output is all-zero when not enabled.
module reg_select #(
  parameter int NREGS = 16
) (
  input  logic             en_i,
  input  logic [3:0]       sel_i,
  output logic [NREGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for data_path: fetch in T0-T2, register-register execute in T3-T6.
// Define CU_MULDIV_EN to sequence mul/div through T5/T6 with LOin/HIin; otherwise they act as nop.
module control_unit
  import cpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             stop,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             ZIn,
  output logic             ZLowout,
  output logic             ZHighout,
  output logic             HIin,
  output logic             LOin,
  output logic [3:0]       ALUselect,
  output logic             run
);

  logic [ST_W-1:0] state_q, state_d;
  logic [3:0]      alu_q, alu_d;
  logic            unary_q, unary_d;
  logic            muldiv_q, muldiv_d;
  op_dec_t         dec;
  logic [3:0]      ra, rb, rc, rout_sel;
  logic            rin_en, rout_en;
  logic            unused_ir;

  assign dec       = decode_op(ir[IR_OP_HI:IR_OP_LO]);
  assign ra        = ir[IR_RA_HI:IR_RA_LO];
  assign rb        = ir[IR_RB_HI:IR_RB_LO];
  assign rc        = ir[IR_RC_HI:IR_RC_LO];
  assign unused_ir = ^ir[IR_RC_LO-1:0];

  // Operation class is captured in T2 so execute-phase strobes stay pure state decode.
  always_comb begin
    state_d  = state_q;
    alu_d    = alu_q;
    unary_d  = unary_q;
    muldiv_d = muldiv_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = stop ? ST_HALT : ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2: begin
        alu_d    = dec.alu;
        unary_d  = dec.unary;
        muldiv_d = dec.muldiv;
        if (dec.halt)      state_d = ST_HALT;
        else if (dec.exec) state_d = ST_T3;
        else               state_d = ST_T0;
      end
      ST_T3:    state_d = ST_T4;
      ST_T4:    state_d = ST_T5;
`ifdef CU_MULDIV_EN
      ST_T5:    state_d = muldiv_q ? ST_T6 : ST_T0;
      ST_T6:    state_d = ST_T0;
`else
      ST_T5:    state_d = ST_T0;
`endif
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= ST_RESET;
      alu_q    <= '0;
      unary_q  <= 1'b0;
      muldiv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_q    <= alu_d;
      unary_q  <= unary_d;
      muldiv_q <= muldiv_d;
    end
  end

  // T0 strobes are state-only; a stop seen in T0 only redirects the next state.
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; IRin = 1'b0;
    Yin = 1'b0; ZIn = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    ALUselect = 4'h0;
    run = 1'b0;
    rin_en = 1'b0;
    rout_en = 1'b0;
    rout_sel = rb;
    case (state_q)
      ST_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
      end
      ST_T1: begin
        run = 1'b1; ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        run = 1'b1; Yin = 1'b1; rout_en = 1'b1;
      end
      ST_T4: begin
        run = 1'b1; ZIn = 1'b1; ALUselect = alu_q; rout_en = 1'b1;
        rout_sel = unary_q ? rb : rc;
      end
      ST_T5: begin
        run = 1'b1; ZLowout = 1'b1;
`ifdef CU_MULDIV_EN
        LOin   = muldiv_q;
`endif
        rin_en = ~muldiv_q;
      end
`ifdef CU_MULDIV_EN
      ST_T6: begin
        run = 1'b1; ZHighout = 1'b1; HIin = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  reg_select #(.NREGS(NREGS)) u_rin_sel (
    .en_i     (rin_en),
    .sel_i    (ra),
    .onehot_o (rin)
  );

  reg_select #(.NREGS(NREGS)) u_rout_sel (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (rout)
  );

endmodule
